mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: data-memory pipeline stage with the MEM/WB register.
// Word-addressed data memory with a BASE_ADDR offset, out-of-range detection
// and a registered MEM/WB interface. Defining MEM_WAIT_EN adds an IDLE/BUSY
// wait-state FSM that stalls upstream for WAIT_CYCLES cycles per access;
// without it every access completes in the cycle it is presented.
module mem_stage #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN,
    input  logic        MEM_R,
    input  logic        MEM_W,
    input  logic [31:0] ALU_res,
    input  logic [31:0] val_rm,
    input  logic [3:0]  dest,
    output logic        freeze,
    output logic        WB_EN_out,
    output logic        MEM_R_out,
    output logic [31:0] ALU_res_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  dest_out,
    output logic        addr_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    logic        req_c;
    logic [31:0] idx_c;
    logic        in_range_c;
    logic [31:0] load_data_c;
    logic        commit_c;

    // Address decode: byte address relative to BASE_ADDR, low two bits dropped.
    always_comb begin
        req_c       = MEM_R | MEM_W;
        idx_c       = (ALU_res - 32'(BASE_ADDR)) >> 2;
        in_range_c  = (idx_c < 32'(DEPTH));
        load_data_c = 32'd0;
        // Only a pure in-range read returns array data; writes (including
        // read+write) and non-memory ops forward zero load data.
        if (MEM_R && !MEM_W && in_range_c) begin
            load_data_c = mem[idx_c[AW-1:0]];
        end
    end

`ifdef MEM_WAIT_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       stall_c;

    // Wait-state FSM registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: IDLE accepts a request and stalls; BUSY counts down, then
    // releases the stall for the single completion cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req_c) begin
                    stall_c   = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = 4'(WAIT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    stall_c = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // No stall is requested while reset is held, so an aborted access
    // releases the pipeline immediately.
    assign freeze = rst & stall_c;
`else
    assign freeze = 1'b0;
`endif

    // A write commits only on a completing, non-reset cycle and in range.
    assign commit_c = rst && !freeze && MEM_W && in_range_c;

    // Data array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem[idx_c[AW-1:0]] <= val_rm;
        end
    end

    // MEM/WB register: bubble on reset or freeze, otherwise load the stage.
    always_ff @(posedge clk) begin
        if (!rst || freeze) begin
            WB_EN_out    <= 1'b0;
            MEM_R_out    <= 1'b0;
            ALU_res_out  <= 32'd0;
            mem_data_out <= 32'd0;
            dest_out     <= 4'd0;
            addr_err     <= 1'b0;
        end else begin
            WB_EN_out    <= WB_EN;
            MEM_R_out    <= MEM_R;
            ALU_res_out  <= ALU_res;
            mem_data_out <= load_data_c;
            dest_out     <= dest;
            addr_err     <= req_c && !in_range_c;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (default build; also adapts to MEM_WAIT_EN).
module tb_mem_stage;

`ifdef MEM_WAIT_EN
    localparam int WAITC = 3;
`else
    localparam int WAITC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN, MEM_R, MEM_W;
    logic [31:0] ALU_res, val_rm;
    logic [3:0]  dest;
    logic        freeze;
    logic        WB_EN_out, MEM_R_out;
    logic [31:0] ALU_res_out, mem_data_out;
    logic [3:0]  dest_out;
    logic        addr_err;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .WB_EN        (WB_EN),
        .MEM_R        (MEM_R),
        .MEM_W        (MEM_W),
        .ALU_res      (ALU_res),
        .val_rm       (val_rm),
        .dest         (dest),
        .freeze       (freeze),
        .WB_EN_out    (WB_EN_out),
        .MEM_R_out    (MEM_R_out),
        .ALU_res_out  (ALU_res_out),
        .mem_data_out (mem_data_out),
        .dest_out     (dest_out),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic        wb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  dest;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        wb;
        logic        re;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  dest;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[13];
    logic [31:0] model[64];
    int          n_pass = 0;
    int          n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Present one access, hold it through the stall, then check the result.
    task automatic do_txn(input logic we, input logic re, input logic wb,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] d, input logic [31:0] exp_data,
                          input logic exp_err);
        exp_t e;
        int   nfz;
        bit   done;
        MEM_W = we; MEM_R = re; WB_EN = wb;
        ALU_res = addr; val_rm = data; dest = d;
        e.wb = wb; e.re = re; e.addr = addr; e.data = exp_data; e.dest = d; e.err = exp_err;
        sb.push_back(e);
        nfz = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!freeze) done = 1'b1;
            else begin
                nfz++;
                @(posedge clk); #1;
                chk("bubble_alu", ALU_res_out, 32'd0);
                chk("bubble_data", mem_data_out, 32'd0);
                chk("bubble_ctl", 32'({WB_EN_out, MEM_R_out, addr_err, dest_out}), 32'd0);
            end
        end
        if (!done) begin
            n_tot++;
            $display("FAIL freeze_timeout: freeze still high after 40 cycles at addr 0x%08h", addr);
        end
        chk("freeze_len", 32'(nfz), (we | re) ? 32'(WAITC) : 32'd0);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("wb_en_out", 32'(WB_EN_out), 32'(e.wb));
        chk("mem_r_out", 32'(MEM_R_out), 32'(e.re));
        chk("alu_res_out", ALU_res_out, e.addr);
        chk("mem_data_out", mem_data_out, e.data);
        chk("dest_out", 32'(dest_out), 32'(e.dest));
        chk("addr_err", 32'(addr_err), 32'(e.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // we re wb addr data dest exp_data exp_err
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd1024, 32'hDEADBEEF, 4'd1, 32'd0,         1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'd1024, 32'd0,        4'd2, 32'hDEADBEEF,  1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd1028, 32'd0,        4'd4, 32'h10000001,  1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd1280, 32'd0,        4'd5, 32'd0,         1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'd1020, 32'd0,        4'd6, 32'd0,         1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'd1280, 32'h00000BAD, 4'd0, 32'd0,         1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'd1020, 32'h00000BAD, 4'd0, 32'd0,         1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'd1032, 32'd5,        4'd7, 32'd0,         1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'd1032, 32'd0,        4'd8, 32'd5,         1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h77,   32'd0,        4'd3, 32'd0,         1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'd1279, 32'd0,        4'd9, 32'h1000003F,  1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 32'd1026, 32'd0,        4'd10, 32'hDEADBEEF, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 32'd0,    32'd0,        4'd11, 32'd0,        1'b1};

        rst = 1'b0; WB_EN = 1'b0; MEM_R = 1'b0; MEM_W = 1'b0;
        ALU_res = 32'd0; val_rm = 32'd0; dest = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_freeze", 32'(freeze), 32'd0);
        chk("reset_ctl", 32'({WB_EN_out, MEM_R_out, addr_err, dest_out}), 32'd0);
        chk("reset_alu", ALU_res_out, 32'd0);
        chk("reset_data", mem_data_out, 32'd0);
        rst = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < 64; i++) begin
            model[i] = 32'h10000000 + 32'(i);
            do_txn(1'b1, 1'b0, 1'b0, 32'd1024 + 32'(4 * i), model[i], 4'd0, 32'd0, 1'b0);
        end

        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i].we, tbl[i].re, tbl[i].wb, tbl[i].addr, tbl[i].data,
                   tbl[i].dest, tbl[i].exp_data, tbl[i].exp_err);
        end
        model[0] = 32'hDEADBEEF;
        model[2] = 32'd5;

        // Out-of-range stores must not have disturbed any word.
        for (int i = 0; i < 64; i++) begin
            do_txn(1'b0, 1'b1, 1'b1, 32'd1024 + 32'(4 * i), 32'd0, 4'(i), model[i], 1'b0);
        end

        // Reset in the middle of a store aborts it.
        MEM_W = 1'b1; MEM_R = 1'b0; WB_EN = 1'b0;
        ALU_res = 32'd1044; val_rm = 32'h1234; dest = 4'd0;
`ifdef MEM_WAIT_EN
        @(negedge clk);
        chk("rst_pre_freeze", 32'(freeze), 32'd1);
        @(posedge clk); #1;
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_abort_freeze", 32'(freeze), 32'd0);
        chk("rst_abort_ctl", 32'({WB_EN_out, MEM_R_out, addr_err, dest_out}), 32'd0);
        chk("rst_abort_alu", ALU_res_out, 32'd0);
        chk("rst_abort_data", mem_data_out, 32'd0);
        MEM_W = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 1'b1, 1'b1, 32'd1044, 32'd0, 4'd12, model[5], 1'b0);

        MEM_R = 1'b0; MEM_W = 1'b0; WB_EN = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
